jtag_debug_cmd_queue: RTL and testbench

System-clock half of the next-generation JTAG debug link. It synchronises the virtual-JTAG update strobes from the TCK domain and captures the scanned shift register and instruction into a DEPTH-entry command queue. On each consumer handshake it issues one-cycle `take_action` or `take_no_action` strobes per instruction code. It sits between the TCK-side scan logic and the CPU debug/OCI blocks, and replaces the fixed-width, unbuffered sysclk strobe generator.

---
 rtl/jtag_debug_cmd_queue.sv | 170 +++++++++++++++++
 tb/tb_jtag_debug_cmd_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_queue.sv
// System-clock side of the JTAG debug link: synchronises the update-DR/IR strobes,
// queues each scanned command, and turns every consumer pop into a one-cycle strobe.
module jtag_debug_cmd_queue #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  input  logic                       cmd_ready,
  input  logic                       clear_overflow,
  output logic                       cmd_valid,
  output logic                       cmd_is_udr,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [SR_W-1:0]            jdo,
  output logic [(2**IR_W)-1:0]       take_action,
  output logic [(2**IR_W)-1:0]       take_no_action,
  output logic                       ir_updated,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int NCMD = 2**IR_W;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  logic [SYNC_STAGES-1:0]       udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d;
  logic                         udr_hist_q, udr_hist_d, uir_hist_q, uir_hist_d;
  logic                         pend_q, pend_d;
  logic [DEPTH-1:0]             kind_q, kind_d;
  logic [DEPTH-1:0][IR_W-1:0]   ir_q, ir_d;
  logic [DEPTH-1:0][SR_W-1:0]   data_q, data_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         ovf_q, ovf_d;
  logic [SR_W-1:0]              jdo_q, jdo_d;
  logic [NCMD-1:0]              ta_q, ta_d, tna_q, tna_d;
  logic                         iru_q, iru_d;

  logic rise_udr, rise_uir, pop, full, space, push_req, push_kind, push, drop;
  logic head_kind;
  logic [IR_W-1:0] head_ir;
  logic [SR_W-1:0] head_data;

  assign head_kind = kind_q[rd_ptr_q];
  assign head_ir   = ir_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  always_comb begin
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_hist_d = udr_sync_q[SYNC_STAGES-1];
    uir_hist_d = uir_sync_q[SYNC_STAGES-1];
    rise_udr   = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
    rise_uir   = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;

    pop   = (count_q != '0) & cmd_ready;
    full  = (count_q == CW'(DEPTH));
    space = ~full | pop;

    push_req  = 1'b0;
    push_kind = 1'b0;
    drop      = 1'b0;
    pend_d    = pend_q;
    // A held UIR goes first and absorbs any new UIR edge; it is never dropped,
    // it simply waits for room. A UDR edge that collides with it is lost.
    if (pend_q) begin
      push_req = 1'b1;
      if (space) pend_d = 1'b0;
      drop = rise_udr;
    end else if (rise_udr) begin
      push_req  = 1'b1;
      push_kind = 1'b1;
      pend_d    = rise_uir;
      drop      = ~space;
    end else if (rise_uir) begin
      push_req = 1'b1;
      drop     = ~space;
    end
    push = push_req & space;

    kind_d   = kind_q;
    ir_d     = ir_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      kind_d[wr_ptr_q] = push_kind;
      ir_d[wr_ptr_q]   = ir_in;
      data_d[wr_ptr_q] = sr;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    ovf_d = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;

    jdo_d = jdo_q;
    ta_d  = '0;
    tna_d = '0;
    iru_d = 1'b0;
    if (pop) begin
      if (head_kind) begin
        jdo_d = head_data;
        if (head_data[SR_W-1]) ta_d[head_ir]  = 1'b1;
        else                   tna_d[head_ir] = 1'b1;
      end else begin
        iru_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_hist_q <= 1'b0;
      uir_hist_q <= 1'b0;
      pend_q     <= 1'b0;
      kind_q     <= '0;
      ir_q       <= '0;
      data_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      jdo_q      <= '0;
      ta_q       <= '0;
      tna_q      <= '0;
      iru_q      <= 1'b0;
    end else begin
      udr_sync_q <= udr_sync_d;
      uir_sync_q <= uir_sync_d;
      udr_hist_q <= udr_hist_d;
      uir_hist_q <= uir_hist_d;
      pend_q     <= pend_d;
      kind_q     <= kind_d;
      ir_q       <= ir_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      jdo_q      <= jdo_d;
      ta_q       <= ta_d;
      tna_q      <= tna_d;
      iru_q      <= iru_d;
    end
  end

  assign cmd_valid      = (count_q != '0);
  assign cmd_is_udr     = head_kind;
  assign cmd_ir         = head_ir;
  assign jdo            = jdo_q;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign ir_updated     = iru_q;
  assign count          = count_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Directed bench for jtag_debug_cmd_queue: default instance (a_*) and a widened
// instance (b_*: SR_W=48, IR_W=3, SYNC_STAGES=3, DEPTH=8).
module tb_jtag_debug_cmd_queue;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic        a_vs_udr = 0, a_vs_uir = 0, a_cmd_ready = 0, a_clear_overflow = 0;
  logic [1:0]  a_ir_in = '0;
  logic [37:0] a_sr = '0;
  logic        a_cmd_valid, a_cmd_is_udr, a_ir_updated, a_overflow;
  logic [1:0]  a_cmd_ir;
  logic [37:0] a_jdo;
  logic [3:0]  a_take_action, a_take_no_action;
  logic [2:0]  a_count;

  logic        b_vs_udr = 0, b_vs_uir = 0, b_cmd_ready = 0, b_clear_overflow = 0;
  logic [2:0]  b_ir_in = '0;
  logic [47:0] b_sr = '0;
  logic        b_cmd_valid, b_cmd_is_udr, b_ir_updated, b_overflow;
  logic [2:0]  b_cmd_ir;
  logic [47:0] b_jdo;
  logic [7:0]  b_take_action, b_take_no_action;
  logic [3:0]  b_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  jtag_debug_cmd_queue dut_a (
    .clk(clk), .reset_n(reset_n), .vs_udr(a_vs_udr), .vs_uir(a_vs_uir),
    .ir_in(a_ir_in), .sr(a_sr), .cmd_ready(a_cmd_ready), .clear_overflow(a_clear_overflow),
    .cmd_valid(a_cmd_valid), .cmd_is_udr(a_cmd_is_udr), .cmd_ir(a_cmd_ir), .jdo(a_jdo),
    .take_action(a_take_action), .take_no_action(a_take_no_action),
    .ir_updated(a_ir_updated), .count(a_count), .overflow(a_overflow)
  );

  jtag_debug_cmd_queue #(.SR_W(48), .IR_W(3), .SYNC_STAGES(3), .DEPTH(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .vs_udr(b_vs_udr), .vs_uir(b_vs_uir),
    .ir_in(b_ir_in), .sr(b_sr), .cmd_ready(b_cmd_ready), .clear_overflow(b_clear_overflow),
    .cmd_valid(b_cmd_valid), .cmd_is_udr(b_cmd_is_udr), .cmd_ir(b_cmd_ir), .jdo(b_jdo),
    .take_action(b_take_action), .take_no_action(b_take_no_action),
    .ir_updated(b_ir_updated), .count(b_count), .overflow(b_overflow)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_udr_a(input logic [1:0] ir, input logic [37:0] s);
    @(negedge clk);
    a_ir_in = ir; a_sr = s; a_vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    a_vs_udr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_udr_b(input logic [2:0] ir, input logic [47:0] s);
    @(negedge clk);
    b_ir_in = ir; b_sr = s; b_vs_udr = 1'b1;
    repeat (3) @(negedge clk);
    b_vs_udr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // counts negedges until cmd_valid, capped at max
  task automatic wait_valid_a(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_cmd_valid && n < max);
  endtask

  task automatic wait_valid_b(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_cmd_valid && n < max);
  endtask

  initial begin
    int n;
    logic [37:0] s;
    logic [47:0] sb;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", W'(a_cmd_valid), 0);
    check("rst_count", W'(a_count), 0);
    check("rst_jdo", W'(a_jdo), 0);
    check("rst_ta", W'(a_take_action), 0);
    check("rst_tna", W'(a_take_no_action), 0);
    check("rst_iru", W'(a_ir_updated), 0);
    check("rst_ovf", W'(a_overflow), 0);
    check("rst_kind", W'(a_cmd_is_udr), 0);
    check("rst_ir", W'(a_cmd_ir), 0);
    reset_n = 1'b1;

    // basic UDR action
    @(negedge clk);
    a_cmd_ready = 1'b1;
    a_ir_in = 2'd1; a_sr = 38'h20_0000_1234; a_vs_udr = 1'b1;
    wait_valid_a(10, n);
    check("basic_latency", W'(n), 3);
    check("basic_count", W'(a_count), 1);
    check("basic_ta_early", W'(a_take_action), 0);
    @(negedge clk);
    check("basic_ta", W'(a_take_action), 4'b0010);
    check("basic_jdo", W'(a_jdo), 38'h20_0000_1234);
    check("basic_tna", W'(a_take_no_action), 0);
    check("basic_drained", W'(a_cmd_valid), 0);
    @(negedge clk);
    a_vs_udr = 1'b0;
    check("basic_ta_one_cycle", W'(a_take_action), 0);
    repeat (4) @(negedge clk);
    check("basic_single_event", W'(a_count), 0);

    // no-action UDR, then UIR
    a_ir_in = 2'd3; a_sr = 38'h00_0000_5678; a_vs_udr = 1'b1;
    wait_valid_a(10, n);
    check("noact_latency", W'(n), 3);
    @(negedge clk);
    check("noact_tna", W'(a_take_no_action), 4'b1000);
    check("noact_ta", W'(a_take_action), 0);
    check("noact_jdo", W'(a_jdo), 38'h00_0000_5678);
    a_vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    a_ir_in = 2'd2; a_vs_uir = 1'b1;
    wait_valid_a(10, n);
    check("uir_latency", W'(n), 3);
    check("uir_kind", W'(a_cmd_is_udr), 0);
    check("uir_ir", W'(a_cmd_ir), 2);
    @(negedge clk);
    check("uir_iru", W'(a_ir_updated), 1);
    check("uir_jdo_kept", W'(a_jdo), 38'h00_0000_5678);
    check("uir_no_ta", W'(a_take_action | a_take_no_action), 0);
    @(negedge clk);
    a_vs_uir = 1'b0;
    check("uir_iru_one_cycle", W'(a_ir_updated), 0);
    repeat (3) @(negedge clk);

    // simultaneous UDR and UIR edges
    a_cmd_ready = 1'b0;
    a_ir_in = 2'd1; a_sr = 38'h3F_0000_00AA; a_vs_udr = 1'b1; a_vs_uir = 1'b1;
    @(negedge clk); check("sim_cnt1", W'(a_count), 0);
    @(negedge clk); check("sim_cnt2", W'(a_count), 0);
    @(negedge clk); check("sim_cnt3", W'(a_count), 1);
    check("sim_head_udr", W'(a_cmd_is_udr), 1);
    @(negedge clk); check("sim_cnt4", W'(a_count), 2);
    a_vs_udr = 1'b0; a_vs_uir = 1'b0; a_cmd_ready = 1'b1;
    @(negedge clk);
    check("sim_pop1_ta", W'(a_take_action), 4'b0010);
    check("sim_pop1_jdo", W'(a_jdo), 38'h3F_0000_00AA);
    check("sim_head_uir", W'(a_cmd_is_udr), 0);
    @(negedge clk);
    check("sim_pop2_iru", W'(a_ir_updated), 1);
    check("sim_empty", W'(a_count), 0);
    a_cmd_ready = 1'b0;
    repeat (3) @(negedge clk);

    // overflow: five UDR events into a 4-entry queue
    for (int i = 0; i < 5; i++) begin
      s = 38'h01_1111_0000 + 38'(i);
      if (i < 4) exp_q.push_back(W'(s));
      pulse_udr_a(2'd0, s);
    end
    check("ovf_count", W'(a_count), 4);
    check("ovf_flag", W'(a_overflow), 1);
    a_clear_overflow = 1'b1;
    @(negedge clk);
    a_clear_overflow = 1'b0;
    check("ovf_cleared", W'(a_overflow), 0);

    // drop coinciding with clear_overflow: set wins
    a_sr = 38'h02_2222_0005; a_vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_clear_overflow = 1'b1;
    @(negedge clk);
    a_clear_overflow = 1'b0;
    check("ovf_set_wins", W'(a_overflow), 1);
    check("ovf_count_held", W'(a_count), 4);
    a_vs_udr = 1'b0;
    repeat (3) @(negedge clk);

    // full queue: push and pop on the same edge
    a_sr = 38'h03_3333_0006; a_vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_cmd_ready = 1'b1;
    @(negedge clk);
    a_cmd_ready = 1'b0;
    check("pp_count", W'(a_count), 4);
    check("pp_jdo", W'(a_jdo), exp_q.pop_front());
    exp_q.push_back(W'(38'h03_3333_0006));
    a_vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    a_cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("drain_a_%0d", i), W'(a_jdo), exp_q.pop_front());
    end
    a_cmd_ready = 1'b0;
    check("drain_a_empty", W'(a_count), 0);

    // reset mid-operation
    for (int i = 0; i < 3; i++) pulse_udr_a(2'd1, 38'h04_0000_0000 + 38'(i));
    check("mid_count", W'(a_count), 3);
    @(negedge clk);
    a_vs_udr = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", W'(a_cmd_valid), 0);
    check("mid_rst_count", W'(a_count), 0);
    check("mid_rst_jdo", W'(a_jdo), 0);
    check("mid_rst_ovf", W'(a_overflow), 0);
    check("mid_rst_strobes", W'({a_take_action, a_take_no_action, a_ir_updated}), 0);
    a_vs_udr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("mid_quiet_%0d", i), W'(a_cmd_valid), 0);
    end

    // widened instance: basic action
    b_cmd_ready = 1'b1;
    b_ir_in = 3'd5; b_sr = 48'h8000_0000_ABCD; b_vs_udr = 1'b1;
    wait_valid_b(12, n);
    check("b_latency", W'(n), 4);
    @(negedge clk);
    check("b_ta", W'(b_take_action), 8'b0010_0000);
    check("b_tna", W'(b_take_no_action), 0);
    check("b_jdo", W'(b_jdo), 48'h8000_0000_ABCD);
    @(negedge clk);
    b_vs_udr = 1'b0;
    check("b_ta_one_cycle", W'(b_take_action), 0);
    repeat (4) @(negedge clk);
    b_cmd_ready = 1'b0;

    // widened instance: overflow with nine events into eight entries
    for (int i = 0; i < 9; i++) begin
      sb = 48'h0000_0100_0000 + 48'(i);
      if (i < 8) exp_q.push_back(W'(sb));
      pulse_udr_b(3'd2, sb);
    end
    check("b_ovf_count", W'(b_count), 8);
    check("b_ovf_flag", W'(b_overflow), 1);
    b_cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("drain_b_%0d", i), W'(b_jdo), exp_q.pop_front());
    end
    b_cmd_ready = 1'b0;
    check("b_drain_empty", W'(b_count), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
